// File: rtl/sm4_key_ctrl.sv
// sm4_key_ctrl
//   Sequencing and arbitration controller for the SM4 key-expansion engine.
//   Two requesters ask for a key load; the winner (round-robin on contention)
//   is either answered from a one-entry key cache (same key and mode) or
//   sent to the engine.  The engine handshake is enable/key/valid with a
//   finished flag guarded by a timeout.  A miss is only started while the
//   cipher datapath is not consuming round keys.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req_in[1:0]             level key-load requests, held until ack
//   key_in[1:0]             128-bit user key per requester
//   encdec_in[1:0]          0 = encrypt round-key order, 1 = decrypt order
//   ack_out[1:0]            one-cycle completion pulse per requester
//   err_out                 qualifies ack: 1 = expansion timed out
//   cipher_busy_in          datapath using round keys; blocks new misses
//   keys_ready_out          round-key registers hold the cached key/mode
//   ek_sm4_enable_out       engine sm4_enable_in (low one cycle on abort)
//   ek_enable_key_exp_out   engine enable_key_exp_in
//   ek_user_key_out         engine user_key_in
//   ek_user_key_valid_out   engine user_key_valid_in (engine starts on rise)
//   ek_encdec_sel_out       engine encdec_sel_in
//   ek_finished_in          engine key_exp_finished_out
module sm4_key_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_in,
  input  logic [1:0][127:0] key_in,
  input  logic [1:0]        encdec_in,
  output logic [1:0]        ack_out,
  output logic              err_out,
  input  logic              cipher_busy_in,
  output logic              keys_ready_out,
  output logic              ek_sm4_enable_out,
  output logic              ek_enable_key_exp_out,
  output logic [127:0]      ek_user_key_out,
  output logic              ek_user_key_valid_out,
  output logic              ek_encdec_sel_out,
  input  logic              ek_finished_in
);

  localparam int unsigned CW_MIN = $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_MIN > 6) ? CW_MIN : 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_DONE,
    ST_RELEASE,
    ST_ABORT
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [127:0]    cur_key;
  logic            cur_mode;
  logic            cur_idx;
  logic [127:0]    cache_key;
  logic            cache_mode;
  logic            cache_valid;
  logic            rr_ptr;
  logic [CW-1:0]   tmo_cnt;

  logic            win_vld;
  logic            win_idx;
  logic            win_hit;
  logic            grant;
  logic            miss_grant;

  logic [1:0]      ack_nxt;
  logic            err_nxt;
  logic            en_nxt;
  logic            kexp_nxt;
  logic            valid_nxt;

  // Round-robin pick: on contention the requester opposite the last grant wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 1'b0;
    unique case (req_in)
      2'b01: begin
        win_vld = 1'b1;
        win_idx = 1'b0;
      end
      2'b10: begin
        win_vld = 1'b1;
        win_idx = 1'b1;
      end
      2'b11: begin
        win_vld = 1'b1;
        win_idx = ~rr_ptr;
      end
      default: begin
        win_vld = 1'b0;
        win_idx = 1'b0;
      end
    endcase
  end

  assign win_hit = cache_valid
                 && (key_in[win_idx] == cache_key)
                 && (encdec_in[win_idx] == cache_mode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus next values of the registered outputs.  The handshake
  // bits are registered from the next state, so they follow the state
  // register cycle-for-cycle while staying low during reset.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    miss_grant = 1'b0;
    ack_nxt    = '0;
    err_nxt    = 1'b0;
    en_nxt     = 1'b1;
    kexp_nxt   = 1'b0;
    valid_nxt  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          if (win_hit) begin
            // A cache hit does not touch the round-key registers, so busy is irrelevant.
            state_nxt = ST_HIT;
            grant     = 1'b1;
          end else if (!cipher_busy_in) begin
            state_nxt  = ST_LOAD;
            grant      = 1'b1;
            miss_grant = 1'b1;
          end
        end
      end
      ST_HIT:     state_nxt = ST_IDLE;
      ST_LOAD:    state_nxt = ST_KICK;
      ST_KICK:    state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ek_finished_in) begin
          state_nxt = ST_DONE;
        end else if (tmo_cnt >= CW'(TIMEOUT)) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_DONE:    state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (!ek_finished_in) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase

    unique case (state_nxt)
      ST_HIT: begin
        ack_nxt[win_idx] = 1'b1;
      end
      ST_LOAD: begin
        kexp_nxt = 1'b1;
      end
      ST_KICK: begin
        kexp_nxt  = 1'b1;
        valid_nxt = 1'b1;
      end
      ST_WAIT: begin
        kexp_nxt = 1'b1;
      end
      ST_DONE: begin
        kexp_nxt         = 1'b1;
        ack_nxt[cur_idx] = 1'b1;
      end
      ST_ABORT: begin
        // Dropping sm4_enable for one cycle resets the engine's own FSM.
        en_nxt           = 1'b0;
        ack_nxt[cur_idx] = 1'b1;
        err_nxt          = 1'b1;
      end
      default: begin
        ack_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_out               <= '0;
      err_out               <= 1'b0;
      ek_sm4_enable_out     <= 1'b0;
      ek_enable_key_exp_out <= 1'b0;
      ek_user_key_valid_out <= 1'b0;
    end else begin
      ack_out               <= ack_nxt;
      err_out               <= err_nxt;
      ek_sm4_enable_out     <= en_nxt;
      ek_enable_key_exp_out <= kexp_nxt;
      ek_user_key_valid_out <= valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_key     <= '0;
      cur_mode    <= 1'b0;
      cur_idx     <= 1'b0;
      cache_key   <= '0;
      cache_mode  <= 1'b0;
      cache_valid <= 1'b0;
      rr_ptr      <= 1'b1;
      tmo_cnt     <= '0;
    end else begin
      if (grant) begin
        rr_ptr  <= win_idx;
        cur_idx <= win_idx;
      end
      // The round-key registers are about to be overwritten, so the cache
      // stops vouching for them from LOAD onwards.
      if (miss_grant) begin
        cur_key     <= key_in[win_idx];
        cur_mode    <= encdec_in[win_idx];
        cache_valid <= 1'b0;
      end
      if (state_nxt == ST_DONE) begin
        cache_key   <= cur_key;
        cache_mode  <= cur_mode;
        cache_valid <= 1'b1;
      end
      if (state == ST_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign keys_ready_out = cache_valid;

  // Key and mode are presented to the engine only while it owns them.
  always_comb begin
    ek_user_key_out   = '0;
    ek_encdec_sel_out = 1'b0;
    unique case (state)
      ST_LOAD, ST_KICK, ST_WAIT, ST_DONE, ST_RELEASE: begin
        ek_user_key_out   = cur_key;
        ek_encdec_sel_out = cur_mode;
      end
      default: begin
        ek_user_key_out   = '0;
        ek_encdec_sel_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sm4_key_ctrl.sv
// Testbench for sm4_key_ctrl: directed requests with a queue of expected acks
// checked by an independent monitor, plus a small engine model.
module tb_sm4_key_ctrl;

  localparam int TMO     = 40;
  localparam int ENG_LAT = 33;

  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_TMO  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_in;
  logic [1:0][127:0] key_in;
  logic [1:0]        encdec_in;
  logic [1:0]        ack_out;
  logic              err_out;
  logic              cipher_busy_in;
  logic              keys_ready_out;
  logic              ek_sm4_enable_out;
  logic              ek_enable_key_exp_out;
  logic [127:0]      ek_user_key_out;
  logic              ek_user_key_valid_out;
  logic              ek_encdec_sel_out;
  logic              ek_finished_in;

  sm4_key_ctrl #(.TIMEOUT(TMO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_in                (req_in),
    .key_in                (key_in),
    .encdec_in             (encdec_in),
    .ack_out               (ack_out),
    .err_out               (err_out),
    .cipher_busy_in        (cipher_busy_in),
    .keys_ready_out        (keys_ready_out),
    .ek_sm4_enable_out     (ek_sm4_enable_out),
    .ek_enable_key_exp_out (ek_enable_key_exp_out),
    .ek_user_key_out       (ek_user_key_out),
    .ek_user_key_valid_out (ek_user_key_valid_out),
    .ek_encdec_sel_out     (ek_encdec_sel_out),
    .ek_finished_in        (ek_finished_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    bit           err;
    bit           kr;
    int           kind;
    logic [127:0] key;
    bit           mode;
    int           exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   vrise  = 0;
  int   vcyc   = 0;
  int   fcyc   = 0;
  int   en_low = 0;
  bit   fin_en = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Engine model: starts on a valid rising edge, raises finished ENG_LAT
  // edges later (unless disabled), holds it until enable_key_exp drops.
  logic     eng_busy;
  logic     eng_vprev;
  int       eng_cnt;

  always @(posedge clk) begin
    if (reset || ek_sm4_enable_out !== 1'b1) begin
      eng_busy       <= 1'b0;
      eng_vprev      <= 1'b0;
      eng_cnt        <= 0;
      ek_finished_in <= 1'b0;
    end else begin
      eng_vprev <= ek_user_key_valid_out;
      if (ek_user_key_valid_out && !eng_vprev) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 0;
      end else if (eng_busy) begin
        if (eng_cnt == ENG_LAT - 1) begin
          eng_busy <= 1'b0;
          if (fin_en) ek_finished_in <= 1'b1;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
      if (!ek_enable_key_exp_out) ek_finished_in <= 1'b0;
    end
  end

  // Monitor: samples on the falling edge, checks engine handshake and pops
  // the scoreboard on every ack.
  logic mon_vprev = 1'b0;
  logic mon_fprev = 1'b0;
  exp_t e;
  int   exp_c;

  always @(negedge clk) begin
    if (!reset) begin
      if (!ek_sm4_enable_out) en_low++;
      if (eng_busy) chk("kexp_stable_while_busy", ek_enable_key_exp_out, 1);
      if (ek_user_key_valid_out && !mon_vprev) begin
        vrise++;
        vcyc = cyc;
        chk("valid_while_busy", eng_busy, 0);
        if (sb.size() == 0) begin
          chk("valid_unexpected", ek_user_key_valid_out, 0);
        end else begin
          chk("valid_kind_not_hit", sb[0].kind != K_HIT, 1);
          chk("engine_key", ek_user_key_out, sb[0].key);
          chk("engine_mode", ek_encdec_sel_out, sb[0].mode);
          chk("keys_ready_low_in_load", keys_ready_out, 0);
        end
      end
      if (ek_finished_in && !mon_fprev) fcyc = cyc;
      if (ack_out != 2'b00) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", ack_out, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", ack_out, 2'b01 << e.idx);
          chk("err", err_out, e.err);
          chk("keys_ready_at_ack", keys_ready_out, e.kr);
          if (e.kind == K_HIT)       exp_c = e.exp_cyc;
          else if (e.kind == K_MISS) exp_c = fcyc + 1;
          else                       exp_c = vcyc + TMO + 2;
          chk("ack_cycle", cyc, exp_c);
        end
      end
    end
    mon_vprev = ek_user_key_valid_out;
    mon_fprev = ek_finished_in;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int i, input logic [127:0] k, input bit m,
                       input int kind, input bit err, input bit kr);
    exp_t x;
    x.idx = i; x.err = err; x.kr = kr; x.kind = kind;
    x.key = k; x.mode = m; x.exp_cyc = cyc + 1;
    sb.push_back(x);
    key_in[i]    = k;
    encdec_in[i] = m;
    req_in[i]    = 1'b1;
  endtask

  task automatic wait_ack(input int i, input int budget);
    int n;
    n = 0;
    while (!ack_out[i] && n < budget) begin
      tick(1);
      n++;
    end
    if (!ack_out[i]) chk("ack_wait", ack_out[i], 1);
    req_in[i] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack_out, 0);
    chk({tag, "_err"}, err_out, 0);
    chk({tag, "_kr"}, keys_ready_out, 0);
    chk({tag, "_en"}, ek_sm4_enable_out, 0);
    chk({tag, "_kexp"}, ek_enable_key_exp_out, 0);
    chk({tag, "_valid"}, ek_user_key_valid_out, 0);
    chk({tag, "_key"}, ek_user_key_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  logic [127:0] k0, ka, kb, kc, kd, ke, kf, kg;
  int exp_v;
  int n;

  initial begin
    k0 = 128'h0123456789ABCDEFFEDCBA9876543210;
    ka = 128'h11112222333344445555666677778888;
    kb = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
    kc = 128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0;
    kd = 128'hD00DD00DD00DD00DD00DD00DD00DD00D;
    ke = 128'hE1E2E3E4E5E6E7E8E9EAEBECEDEEEF00;
    kf = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    kg = 128'h0A0B0C0D0E0F10111213141516171819;
    reset = 1'b1; req_in = '0; key_in = '0; encdec_in = '0; cipher_busy_in = 1'b0;
    exp_v = 0;

    tick(3);
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick(1);
    chk("en_after_reset", ek_sm4_enable_out, 1);
    chk("kr_after_reset", keys_ready_out, 0);
    tick(2);

    // Miss on requester 0, encrypt.
    issue(0, k0, 1'b0, K_MISS, 1'b0, 1'b1);
    wait_ack(0, 100);
    exp_v++;
    tick(5);
    chk("vrise_miss0", vrise, exp_v);

    // Same key/mode on requester 1 with busy high: hit, no engine activity.
    cipher_busy_in = 1'b1;
    issue(1, k0, 1'b0, K_HIT, 1'b0, 1'b1);
    wait_ack(1, 10);
    cipher_busy_in = 1'b0;
    tick(5);
    chk("vrise_hit", vrise, exp_v);

    // Same key, decrypt order: a miss.
    issue(1, k0, 1'b1, K_MISS, 1'b0, 1'b1);
    wait_ack(1, 100);
    exp_v++;
    tick(5);
    chk("vrise_decrypt", vrise, exp_v);

    // Contention with rr pointer at 1: requester 0 first.
    issue(0, ka, 1'b0, K_MISS, 1'b0, 1'b1);
    issue(1, kb, 1'b0, K_MISS, 1'b0, 1'b1);
    fork
      wait_ack(0, 200);
      wait_ack(1, 200);
    join
    exp_v += 2;
    tick(5);
    chk("vrise_contend1", vrise, exp_v);

    // Hit on requester 0 moves the rr pointer to 0.
    issue(0, kb, 1'b0, K_HIT, 1'b0, 1'b1);
    wait_ack(0, 10);
    tick(5);

    // Contention with rr pointer at 0: requester 1 first.
    issue(1, kd, 1'b0, K_MISS, 1'b0, 1'b1);
    issue(0, kc, 1'b1, K_MISS, 1'b0, 1'b1);
    fork
      wait_ack(0, 200);
      wait_ack(1, 200);
    join
    exp_v += 2;
    tick(5);
    chk("vrise_contend2", vrise, exp_v);

    // Miss held off by cipher_busy_in.
    cipher_busy_in = 1'b1;
    issue(0, ke, 1'b0, K_MISS, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("busy_no_kexp", ek_enable_key_exp_out, 0);
    end
    chk("vrise_busy_block", vrise, exp_v);
    cipher_busy_in = 1'b0;
    n = 0;
    while (vrise == exp_v && n < 10) begin
      tick(1);
      n++;
    end
    exp_v++;
    chk("vrise_after_busy", vrise, exp_v);
    cipher_busy_in = 1'b1;   // rising mid-expansion must be ignored
    wait_ack(0, 100);
    cipher_busy_in = 1'b0;
    tick(5);

    // Timeout: engine never finishes.
    fin_en = 1'b0;
    en_low = 0;
    issue(0, kf, 1'b0, K_TMO, 1'b1, 1'b0);
    wait_ack(0, 100);
    exp_v++;
    tick(5);
    chk("abort_en_low_cycles", en_low, 1);
    chk("kr_after_abort", keys_ready_out, 0);
    fin_en = 1'b1;
    issue(0, kf, 1'b0, K_MISS, 1'b0, 1'b1);
    wait_ack(0, 100);
    exp_v++;
    tick(5);
    chk("vrise_retry_after_abort", vrise, exp_v);

    // Reset during WAIT: no ack, cache invalid.
    issue(1, kg, 1'b1, K_MISS, 1'b0, 1'b1);
    n = 0;
    while (vrise == exp_v && n < 10) begin
      tick(1);
      n++;
    end
    exp_v++;
    chk("vrise_before_reset", vrise, exp_v);
    tick(5);
    reset = 1'b1;
    req_in[1] = 1'b0;
    sb.delete();
    tick(2);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    tick(1);
    chk("en_after_midreset", ek_sm4_enable_out, 1);
    tick(20);
    // Previously cached key must now be a miss.
    issue(0, kf, 1'b0, K_MISS, 1'b0, 1'b1);
    wait_ack(0, 100);
    exp_v++;
    tick(5);
    chk("vrise_miss_after_reset", vrise, exp_v);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_key_ctrl.md
# sm4_key_ctrl

Sequencing and arbitration controller for the SM4 key-expansion engine. It accepts key-load requests from two requesters (e.g. two cipher channels), arbitrates round-robin, and drives the engine's enable/key/valid handshake. It waits for the finished flag with a timeout and releases the engine cleanly. A one-entry key cache answers repeat requests (same key and mode) without re-expanding. Expansion is blocked while the cipher datapath is consuming round keys.

## Interface
- TIMEOUT, 40, max cycles in WAIT before abort; must exceed engine latency (33 cycles)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_in[i] (i=0,1)  in  1  key-load request; level, held until ack
- key_in[i]  in  128  user key; stable while req high
- encdec_in[i]  in  1  0=encrypt order, 1=decrypt order
- ack_out[i]  out  1  one-cycle completion pulse to requester i
- err_out  out  1  valid with ack; 1 = expansion timed out
- cipher_busy_in  in  1  datapath is using round keys; blocks misses
- keys_ready_out  out  1  round-key registers hold the cached key/mode
- ek_sm4_enable_out  out  1  to engine sm4_enable_in
- ek_enable_key_exp_out  out  1  to engine enable_key_exp_in
- ek_user_key_out  out  128  to engine user_key_in
- ek_user_key_valid_out  out  1  to engine user_key_valid_in; the engine starts on its rising edge
- ek_encdec_sel_out  out  1  to engine encdec_sel_in
- ek_finished_in  in  1  from engine key_exp_finished_out

## Operation
- State encoding and RTL scaffold:
  - States: IDLE, HIT, LOAD, KICK, WAIT, DONE, RELEASE, ABORT.
  - Registers: cur key (128), cur mode, cur index, cache key (128), cache mode, cache_valid, rr pointer, timeout counter (6 bits minimum; size to TIMEOUT).
- Arbitration (IDLE only):
  - Candidates are the requesters with req high.
  - If both are high, grant the requester opposite the rr pointer.
  - rr pointer becomes the granted index on every grant, hit or miss.
  - rr pointer resets to 1, so requester 0 wins the first contention.
- Hit: the winner has key == cache key, mode == cache mode, and cache_valid=1.
  - Go to HIT; cipher_busy_in is ignored.
- Miss: go to LOAD only when cipher_busy_in=0; otherwise stay in IDLE with no grant.
- Per-state outputs:
  - IDLE: all ek_* low except ek_sm4_enable_out=1.
  - HIT: ack_out[winner]=1 for one cycle, err_out=0. Next state IDLE.
  - LOAD: capture winner key/mode into cur. Drive ek_user_key_out/ek_encdec_sel_out from cur from this state through RELEASE. ek_enable_key_exp_out=1, valid=0. cache_valid←0, keys_ready_out←0. Next state KICK.
  - KICK: valid=1 (rising edge seen by engine). Next state WAIT.
  - WAIT: enable=1, valid=0, timeout counter increments. On ek_finished_in=1 go to DONE. When the counter reaches TIMEOUT go to ABORT.
  - DONE: ack_out[cur idx]=1, err_out=0. Cache←cur, cache_valid←1, keys_ready_out←1. Next state RELEASE.
  - RELEASE: enable_key_exp=0. Stay while ek_finished_in=1; go to IDLE when it reads 0.
  - ABORT: ek_sm4_enable_out=0 for exactly one cycle (resets engine FSM). ack_out[cur idx]=1, err_out=1. cache_valid stays 0. Next state IDLE.
- Requester rule: req is dropped at the edge where ack is sampled high. The controller therefore never re-grants the same request.
- Reset: state IDLE. All outputs 0, except ek_sm4_enable_out, which goes to 1 on the first cycle after reset. cache_valid=0, counters 0.
- Reset mid-operation: reset wins from any state. The engine is re-enabled from IDLE. No ack is issued for the interrupted request.
- No ek_enable_key_exp_out change and no new valid edge occur while the engine is expanding.

## Timing
- Outputs are registered, except ek_* decoded from the registered state (glitch-free, state-only decode).
- Hit latency: req sampled high in IDLE at edge N; ack high in cycle N+1.
- Miss latency:
  - LOAD at N+1, KICK at N+2, WAIT from N+3.
  - Engine finished arrives about 33 cycles after the valid edge.
  - ack is the cycle after finished is sampled.
  - RELEASE lasts at least one cycle.
- Minimum spacing between two misses: engine latency + 5 cycles.
- Timeout: ack with err_out=1 exactly TIMEOUT+1 cycles after entering WAIT.
- cipher_busy_in rising while in LOAD..RELEASE has no effect; the gate is checked only in IDLE.

## Test plan
- Reset, then req0 with key 0123456789ABCDEFFEDCBA9876543210, enc: one valid edge, ack0 after finished. Round key 0 = F12186F9, keys_ready_out=1, err_out=0.
- Same key/mode on req1 afterwards: ack1 next cycle, no ek_user_key_valid_out edge, engine untouched.
- Same key with decrypt mode: treated as a miss and re-expanded; keys_ready_out low from LOAD until DONE.
- req0 and req1 high together with different keys, twice: grants go 0,1 then 1,0 per rr pointer; each requester gets exactly one ack per request.
- Engine model never asserts finished, TIMEOUT=40: ack with err_out=1 at WAIT+41. ek_sm4_enable_out low for one cycle; the next same-key request is a miss.
- Miss request with cipher_busy_in=1 for 10 cycles: no LOAD until busy drops, then normal sequence. Reset asserted during WAIT: IDLE, no ack, cache invalid.
